// File: rtl/detector_jogada.sv
// detector_jogada: input conditioning for the four play switches.
// Synchronizes the raw switches, debounces press and release, accepts only
// one-hot presses and emits a single-cycle pulse per press-and-release.
// Port names follow the board-level interface; reset is active-low.
module detector_jogada #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             limpa,
    input  logic [WIDTH-1:0] chaves,
    output logic [WIDTH-1:0] jogada,
    output logic             jogada_feita,
    output logic             jogada_invalida,
    output logic [2:0]       db_estado
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [2:0] {
        INICIAL        = 3'd0,
        ESPERA_ZERO    = 3'd1,
        ESPERA_JOGADA  = 3'd2,
        FILTRA         = 3'd3,
        REGISTRA       = 3'd4,
        ESPERA_SOLTURA = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] jogada_q, jogada_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             feita_q, feita_d;
    logic             inval_q, inval_d;

    logic [WIDTH-1:0] chavesS;
    logic [CW-1:0]    cntInc;
    logic             isZero;
    logic             candOneHot;

    assign chavesS    = sync2_q;
    assign isZero     = (chavesS == '0);
    assign cntInc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    assign candOneHot = (cand_q != '0) && ((cand_q & (cand_q - WIDTH'(1))) == '0);

    // Two-flop synchronizer for the asynchronous switch inputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= chaves;
            sync2_q <= sync1_q;
        end
    end

    // State, stability counter, candidate, play register and pulse registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= INICIAL;
            cnt_q    <= '0;
            cand_q   <= '0;
            jogada_q <= '0;
            feita_q  <= 1'b0;
            inval_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            jogada_q <= jogada_d;
            feita_q  <= feita_d;
            inval_q  <= inval_d;
        end
    end

    // Next-state logic; pulses are computed in REGISTRA and registered so they appear one cycle later
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        jogada_d = jogada_q;
        feita_d  = 1'b0;
        inval_d  = 1'b0;

        case (state_q)
            INICIAL: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = ESPERA_ZERO;
                end
            end
            ESPERA_ZERO, ESPERA_SOLTURA: begin
                if (isZero) begin
                    cnt_d = cntInc;
                    if (cntInc == CNT_MAX) begin
                        state_d = ESPERA_JOGADA;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ESPERA_JOGADA: begin
                if (!isZero) begin
                    state_d = FILTRA;
                    cand_d  = chavesS;
                    cnt_d   = CW'(1);
                end
            end
            FILTRA: begin
                if (isZero) begin
                    state_d = ESPERA_JOGADA;
                    cnt_d   = '0;
                end else if (chavesS != cand_q) begin
                    cand_d = chavesS;
                    cnt_d  = CW'(1);
                end else begin
                    cnt_d = cntInc;
                    if (cntInc == CNT_MAX) begin
                        state_d = REGISTRA;
                    end
                end
            end
            REGISTRA: begin
                if (candOneHot) begin
                    jogada_d = cand_q;
                    feita_d  = 1'b1;
                end else begin
                    inval_d = 1'b1;
                end
                state_d = ESPERA_SOLTURA;
                cnt_d   = '0;
            end
            default: begin
                state_d = INICIAL;
                cnt_d   = '0;
            end
        endcase

        if (!enable) begin
            state_d  = INICIAL;
            cnt_d    = '0;
            cand_d   = '0;
            jogada_d = jogada_q;
            feita_d  = 1'b0;
            inval_d  = 1'b0;
        end

        if (limpa) begin
            jogada_d = '0;
        end
    end

    assign jogada          = jogada_q;
    assign jogada_feita    = feita_q;
    assign jogada_invalida = inval_q;
    assign db_estado       = state_q;

endmodule

// File: tb/tb_detector_jogada.sv
// tb_detector_jogada: directed stimulus with a pulse scoreboard.
`timescale 1us/1ns
module tb_detector_jogada;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       limpa;
    logic [3:0] chaves;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       jogada_invalida;
    logic [2:0] db_estado;

    typedef struct {
        logic       feita;
        logic [3:0] jogada;
        int         due;
    } exp_t;

    exp_t sbQ[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    detector_jogada #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .limpa           (limpa),
        .chaves          (chaves),
        .jogada          (jogada),
        .jogada_feita    (jogada_feita),
        .jogada_invalida (jogada_invalida),
        .db_estado       (db_estado)
    );

    // 1 kHz clock
    initial clock = 1'b0;
    always #500 clock = ~clock;

    // Count rising edges so expected pulse times can be stated in cycles
    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // A clean press changed at negedge cycle c pulses at negedge cycle c+7
    task automatic pushExp(input logic feita, input logic [3:0] jog);
        exp_t e;
        e.feita  = feita;
        e.jogada = jog;
        e.due    = cyc + 7;
        sbQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] v, input int hold);
        chaves = v;
        repeat (hold) @(negedge clock);
    endtask

    // Monitor: every pulse must match the oldest expectation in kind, play value and cycle
    always @(negedge clock) begin
        if (reset && (jogada_feita || jogada_invalida)) begin
            compared++;
            if (sbQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_pulse: feita=%0b invalida=%0b jogada=%b, expected none (cycle %0d)",
                         jogada_feita, jogada_invalida, jogada, cyc);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                if (jogada_feita !== e.feita || jogada_invalida !== !e.feita ||
                    jogada !== e.jogada || cyc != e.due) begin
                    mismatched++;
                    $display("[TB] FAIL pulse: got feita=%0b invalida=%0b jogada=%b cycle=%0d, expected feita=%0b invalida=%0b jogada=%b cycle=%0d",
                             jogada_feita, jogada_invalida, jogada, cyc,
                             e.feita, !e.feita, e.jogada, e.due);
                end
            end
        end
    end

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        limpa  = 1'b0;
        chaves = 4'b0000;

        // Reset held for one period
        @(negedge clock);
        checkOutput("reset_estado", int'(db_estado), 0);
        checkOutput("reset_jogada", int'(jogada), 0);
        checkOutput("reset_feita", int'(jogada_feita), 0);
        checkOutput("reset_invalida", int'(jogada_invalida), 0);
        reset = 1'b1;
        @(negedge clock);

        // Arm detection with switches at rest
        enable = 1'b1;
        @(negedge clock);
        checkOutput("arm_espera_zero", int'(db_estado), 1);
        repeat (9) @(negedge clock);
        checkOutput("arm_espera_jogada", int'(db_estado), 2);
        checkOutput("arm_jogada", int'(jogada), 0);
        checkOutput("arm_feita", int'(jogada_feita), 0);

        // Clean press of switch 0
        pushExp(1'b1, 4'b0001);
        applyStimulus(4'b0001, 10);
        applyStimulus(4'b0000, 10);
        checkOutput("press0_jogada", int'(jogada), 1);
        checkOutput("press0_estado", int'(db_estado), 2);

        // Short glitch is ignored, following press of switch 2 is accepted
        applyStimulus(4'b0010, 2);
        applyStimulus(4'b0000, 3);
        pushExp(1'b1, 4'b0100);
        applyStimulus(4'b0100, 10);
        applyStimulus(4'b0000, 10);
        checkOutput("press2_jogada", int'(jogada), 4);
        checkOutput("press2_estado", int'(db_estado), 2);

        // Two switches together: invalid pulse, previous play kept
        pushExp(1'b0, 4'b0100);
        applyStimulus(4'b0011, 10);
        applyStimulus(4'b0000, 10);
        checkOutput("invalid_jogada", int'(jogada), 4);
        checkOutput("invalid_estado", int'(db_estado), 2);

        // Enable dropped while filtering a press
        applyStimulus(4'b1000, 3);
        checkOutput("dis_filtra", int'(db_estado), 3);
        enable = 1'b0;
        @(negedge clock);
        checkOutput("dis_inicial", int'(db_estado), 0);
        enable = 1'b1;
        @(negedge clock);
        checkOutput("dis_espera_zero", int'(db_estado), 1);
        repeat (10) @(negedge clock);
        checkOutput("dis_held_no_play", int'(db_estado), 1);
        applyStimulus(4'b0000, 8);
        checkOutput("dis_rearmed", int'(db_estado), 2);
        pushExp(1'b1, 4'b1000);
        applyStimulus(4'b1000, 10);
        applyStimulus(4'b0000, 10);
        checkOutput("dis_new_play", int'(jogada), 8);

        // Reset asserted mid-filter clears everything immediately
        chaves = 4'b0001;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("midrst_estado", int'(db_estado), 0);
        checkOutput("midrst_jogada", int'(jogada), 0);
        checkOutput("midrst_feita", int'(jogada_feita), 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (12) @(negedge clock);
        checkOutput("midrst_held", int'(db_estado), 1);
        applyStimulus(4'b0000, 8);
        checkOutput("midrst_rearmed", int'(db_estado), 2);

        // Clear coinciding with the register cycle: pulse issued, play cleared
        pushExp(1'b1, 4'b0000);
        chaves = 4'b0010;
        repeat (6) @(negedge clock);
        limpa = 1'b1;
        @(negedge clock);
        limpa = 1'b0;
        repeat (3) @(negedge clock);
        applyStimulus(4'b0000, 10);
        checkOutput("limpa_jogada", int'(jogada), 0);

        repeat (3) @(negedge clock);
        checkOutput("pending_pulses", sbQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
